// File: rtl/fact_mmio_responder_pkg.sv
// Shared register map, FSM state encodings and STATUS bit positions
// for the memory-mapped factorial responder.
package fact_mmio_responder_pkg;

  localparam logic [1:0] FACT_N      = 2'd0;
  localparam logic [1:0] FACT_GO     = 2'd1;
  localparam logic [1:0] FACT_STATUS = 2'd2;
  localparam logic [1:0] FACT_RESULT = 2'd3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CALC = 1'b1;

  localparam int STAT_DONE = 0;
  localparam int STAT_ERR  = 1;
  localparam int STAT_BUSY = 2;

endpackage

// File: rtl/fact_mmio_responder_engine.sv
// Iterative n! engine: one multiply per cycle, done/RESULT max(N,1) edges after start.
// A start while CALC is running is ignored; done/err are sticky until the next accepted start.
module fact_engine
  import fact_mmio_responder_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_W    = 4,
  parameter int MAX_N  = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [N_W-1:0]    n_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [DATA_W-1:0] result_o
);

  localparam logic [N_W-1:0]    MAX_N_V = N_W'(MAX_N);
  localparam logic [N_W-1:0]    CNT_ONE = N_W'(1);
  localparam logic [DATA_W-1:0] ACC_ONE = DATA_W'(1);

  logic [0:0]        state_q, state_d;
  logic [N_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W+N_W-1:0] prod;

  // Full-width product, truncated to DATA_W when stored back.
  assign prod = {{N_W{1'b0}}, acc_q} * {{DATA_W{1'b0}}, cnt_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    done_d   = done_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          done_d = 1'b0;
          err_d  = 1'b0;
          if (n_i > MAX_N_V) begin
            err_d    = 1'b1;
            done_d   = 1'b1;
            result_d = '0;
          end else begin
            cnt_d   = n_i;
            acc_d   = ACC_ONE;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (cnt_q > CNT_ONE) begin
          acc_d = prod[DATA_W-1:0];
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          result_d = acc_q;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign busy_o   = (state_q == ST_CALC);
  assign done_o   = done_q;
  assign err_o    = err_q;
  assign result_o = result_q;

endmodule

// File: rtl/fact_mmio_responder.sv
// Factorial accelerator on the data-memory bus: loads answered combinationally, stores taken on the edge.
// No backpressure: the bus never stalls; GO while busy is dropped and software polls STATUS.
module fact_mmio_responder
  import fact_mmio_responder_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_W    = 4,
  parameter int MAX_N  = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sel_i,
  input  logic              we_i,
  input  logic [1:0]        a_i,
  input  logic [DATA_W-1:0] wd_i,
  output logic [DATA_W-1:0] rd_o
);

  logic [N_W-1:0]    n_q, n_d;
  logic              wr_n, start;
  logic              busy, done, err;
  logic [DATA_W-1:0] result;
  logic              unused_wd;

  assign unused_wd = ^wd_i[DATA_W-1:N_W];

  assign wr_n  = sel_i && we_i && (a_i == FACT_N);
  assign start = sel_i && we_i && (a_i == FACT_GO) && wd_i[0];
  assign n_d   = wr_n ? wd_i[N_W-1:0] : n_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      n_q <= '0;
    end else begin
      n_q <= n_d;
    end
  end

  fact_engine #(
    .DATA_W (DATA_W),
    .N_W    (N_W),
    .MAX_N  (MAX_N)
  ) u_engine (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (start),
    .n_i      (n_q),
    .busy_o   (busy),
    .done_o   (done),
    .err_o    (err),
    .result_o (result)
  );

  // The SoC decoder ORs responders together, so deselected reads must be zero.
  always_comb begin
    rd_o = '0;
    if (sel_i) begin
      case (a_i)
        FACT_N: rd_o = {{(DATA_W-N_W){1'b0}}, n_q};
        FACT_STATUS: begin
          rd_o[STAT_BUSY] = busy;
          rd_o[STAT_ERR]  = err;
          rd_o[STAT_DONE] = done;
        end
        FACT_RESULT: rd_o = result;
        default:     rd_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_fact_mmio_responder.sv
// Directed self-checking bench for fact_mmio_responder.
module tb_fact_mmio_responder;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        sel_i;
  logic        we_i;
  logic [1:0]  a_i;
  logic [31:0] wd_i;
  logic [31:0] rd_o;

  int passed = 0;
  int total  = 0;

  fact_mmio_responder dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .sel_i  (sel_i),
    .we_i   (we_i),
    .a_i    (a_i),
    .wd_i   (wd_i),
    .rd_o   (rd_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic s, input logic [1:0] addr, input logic [31:0] d);
    @(negedge clk_i);
    sel_i = s; we_i = 1'b1; a_i = addr; wd_i = d;
    @(posedge clk_i);
    #1;
    sel_i = 1'b0; we_i = 1'b0; wd_i = '0;
  endtask

  task automatic rd(input logic [1:0] addr, output logic [31:0] v);
    sel_i = 1'b1; we_i = 1'b0; a_i = addr;
    #1;
    v = rd_o;
    sel_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst_ni = 1'b0; sel_i = 1'b0; we_i = 1'b0; a_i = 2'd0; wd_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    rd(2'd2, v); total++;
    if (v !== 32'd0) $display("FAIL reset_status_in_rst got %0h want 0", v); else passed++;
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 1) continue;
      rd(2'(i), v); total++;
      if (v !== 32'd0) $display("FAIL reset_reg%0d got %0h want 0", i, v); else passed++;
    end
  endtask

  task automatic test_fact5();
    logic [31:0] v;
    wr(1'b1, 2'd0, 32'd5);
    rd(2'd0, v); total++;
    if (v !== 32'd5) $display("FAIL n_readback got %0d want 5", v); else passed++;
    wr(1'b1, 2'd1, 32'd1);
    for (int i = 0; i < 5; i++) begin
      rd(2'd2, v); total++;
      if (v !== 32'h4) $display("FAIL f5_busy_cyc%0d got %0h want 4", i, v); else passed++;
      if (i < 4) tick();
    end
    tick();
    rd(2'd2, v); total++;
    if (v !== 32'h1) $display("FAIL f5_status got %0h want 1", v); else passed++;
    rd(2'd3, v); total++;
    if (v !== 32'd120) $display("FAIL f5_result got %0d want 120", v); else passed++;
    rd(2'd1, v); total++;
    if (v !== 32'd0) $display("FAIL go_read got %0h want 0", v); else passed++;
  endtask

  task automatic test_bounds();
    logic [31:0] v;
    wr(1'b1, 2'd0, 32'd0);
    wr(1'b1, 2'd1, 32'd1);
    rd(2'd2, v); total++;
    if (v !== 32'h4) $display("FAIL f0_busy got %0h want 4", v); else passed++;
    tick();
    rd(2'd2, v); total++;
    if (v !== 32'h1) $display("FAIL f0_status got %0h want 1", v); else passed++;
    rd(2'd3, v); total++;
    if (v !== 32'd1) $display("FAIL f0_result got %0d want 1", v); else passed++;
    wr(1'b1, 2'd0, 32'd12);
    wr(1'b1, 2'd1, 32'd1);
    repeat (11) tick();
    rd(2'd2, v); total++;
    if (v !== 32'h4) $display("FAIL f12_busy_at11 got %0h want 4", v); else passed++;
    tick();
    rd(2'd2, v); total++;
    if (v !== 32'h1) $display("FAIL f12_status got %0h want 1", v); else passed++;
    rd(2'd3, v); total++;
    if (v !== 32'd479001600) $display("FAIL f12_result got %0d want 479001600", v); else passed++;
  endtask

  task automatic test_err();
    logic [31:0] v;
    wr(1'b1, 2'd0, 32'd13);
    wr(1'b1, 2'd1, 32'd1);
    rd(2'd2, v); total++;
    if (v !== 32'h3) $display("FAIL err_status got %0h want 3", v); else passed++;
    rd(2'd3, v); total++;
    if (v !== 32'd0) $display("FAIL err_result got %0d want 0", v); else passed++;
    repeat (3) tick();
    rd(2'd2, v); total++;
    if (v !== 32'h3) $display("FAIL err_sticky got %0h want 3", v); else passed++;
    wr(1'b1, 2'd0, 32'd3);
    wr(1'b1, 2'd1, 32'd1);
    rd(2'd2, v); total++;
    if (v !== 32'h4) $display("FAIL err_cleared got %0h want 4", v); else passed++;
    repeat (3) tick();
    rd(2'd2, v); total++;
    if (v !== 32'h1) $display("FAIL f3_status got %0h want 1", v); else passed++;
    rd(2'd3, v); total++;
    if (v !== 32'd6) $display("FAIL f3_result got %0d want 6", v); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    wr(1'b1, 2'd0, 32'd6);
    wr(1'b1, 2'd1, 32'd1);
    wr(1'b1, 2'd0, 32'd2);
    wr(1'b1, 2'd1, 32'd1);
    rd(2'd0, v); total++;
    if (v !== 32'd2) $display("FAIL busy_n_write got %0d want 2", v); else passed++;
    repeat (3) tick();
    rd(2'd2, v); total++;
    if (v !== 32'h4) $display("FAIL f6_busy got %0h want 4", v); else passed++;
    tick();
    rd(2'd2, v); total++;
    if (v !== 32'h1) $display("FAIL f6_status got %0h want 1", v); else passed++;
    rd(2'd3, v); total++;
    if (v !== 32'd720) $display("FAIL f6_result got %0d want 720", v); else passed++;
    wr(1'b1, 2'd1, 32'd0);
    wr(1'b1, 2'd2, 32'hFF);
    wr(1'b1, 2'd3, 32'h1234);
    rd(2'd2, v); total++;
    if (v !== 32'h1) $display("FAIL ignored_stores_status got %0h want 1", v); else passed++;
    rd(2'd3, v); total++;
    if (v !== 32'd720) $display("FAIL ignored_stores_result got %0d want 720", v); else passed++;
    wr(1'b1, 2'd1, 32'd1);
    tick();
    rd(2'd2, v); total++;
    if (v !== 32'h4) $display("FAIL f2_busy got %0h want 4", v); else passed++;
    rd(2'd3, v); total++;
    if (v !== 32'd720) $display("FAIL f2_result_hold got %0d want 720", v); else passed++;
    tick();
    rd(2'd3, v); total++;
    if (v !== 32'd2) $display("FAIL f2_result got %0d want 2", v); else passed++;
  endtask

  task automatic test_reset_mid_calc();
    logic [31:0] v;
    wr(1'b1, 2'd0, 32'd10);
    wr(1'b1, 2'd1, 32'd1);
    repeat (3) tick();
    rst_ni = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), v); total++;
      if (v !== 32'd0) $display("FAIL midrst_reg%0d got %0h want 0", i, v); else passed++;
    end
    tick();
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    rd(2'd2, v); total++;
    if (v !== 32'd0) $display("FAIL post_rst_status got %0h want 0", v); else passed++;
    wr(1'b1, 2'd0, 32'd4);
    wr(1'b1, 2'd1, 32'd1);
    repeat (4) tick();
    rd(2'd2, v); total++;
    if (v !== 32'h1) $display("FAIL f4_status got %0h want 1", v); else passed++;
    rd(2'd3, v); total++;
    if (v !== 32'd24) $display("FAIL f4_result got %0d want 24", v); else passed++;
    wr(1'b0, 2'd0, 32'd7);
    wr(1'b0, 2'd1, 32'd1);
    rd(2'd0, v); total++;
    if (v !== 32'd4) $display("FAIL nosel_n got %0d want 4", v); else passed++;
    rd(2'd2, v); total++;
    if (v !== 32'h1) $display("FAIL nosel_status got %0h want 1", v); else passed++;
    sel_i = 1'b0; a_i = 2'd3;
    #1; total++;
    if (rd_o !== 32'd0) $display("FAIL nosel_rd got %0h want 0", rd_o); else passed++;
  endtask

  initial begin
    test_reset();
    test_fact5();
    test_bounds();
    test_err();
    test_back_to_back();
    test_reset_mid_calc();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
